// File: rtl/irq_timer_pkg.sv
// Shared definitions for the reload timer: register offsets from the
// timer base address, TCON bit positions, and the register select codes
// produced by the address decoder.
package irq_timer_pkg;

    localparam logic [31:0] TH_OFS   = 32'h0000_0000;
    localparam logic [31:0] TL_OFS   = 32'h0000_0004;
    localparam logic [31:0] TCON_OFS = 32'h0000_0008;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_TH   = 2'd1,
        SEL_TL   = 2'd2,
        SEL_TCON = 2'd3
    } regSel_t;

endpackage

// File: rtl/irq_timer.sv
// Memory-mapped reload timer on the MEM-stage data bus. TL counts up
// every cycle while enabled and reloads from TH when it passes all-ones;
// that overflow latches the interrupt status, which stays up until
// software clears TCON.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          WIDTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             Hit,
    output logic             IRQ
);

    logic [WIDTH-1:0] th;
    logic [WIDTH-1:0] tl;
    logic [2:0]       tcon;

    logic [WIDTH-1:0] tlNext;
    logic [2:0]       tconNext;

    regSel_t sel;
    logic    wrTh;
    logic    wrTl;
    logic    wrTcon;
    logic    overflow;

    // Exact word-aligned match on the three register addresses
    always_comb begin
        sel = SEL_NONE;
        if (Addr[1:0] == 2'b00) begin
            if (Addr == BASE_ADDR + TH_OFS)
                sel = SEL_TH;
            else if (Addr == BASE_ADDR + TL_OFS)
                sel = SEL_TL;
            else if (Addr == BASE_ADDR + TCON_OFS)
                sel = SEL_TCON;
        end
    end

    assign Hit      = (sel != SEL_NONE);
    assign wrTh     = MemWrite && (sel == SEL_TH);
    assign wrTl     = MemWrite && (sel == SEL_TL);
    assign wrTcon   = MemWrite && (sel == SEL_TCON);
    assign overflow = tcon[TCON_EN] && (tl == {WIDTH{1'b1}});
    assign IRQ      = tcon[TCON_IE] && tcon[TCON_ST];

    // Next TL/TCON: a TL store beats both reload and increment, and an
    // overflow seen with the old interrupt enable sets status even if the
    // same store tries to clear it, so no interrupt is dropped
    always_comb begin
        tlNext = tl;
        if (wrTl)
            tlNext = WriteData;
        else if (overflow)
            tlNext = th;
        else if (tcon[TCON_EN])
            tlNext = tl + {{(WIDTH-1){1'b0}}, 1'b1};

        tconNext = tcon;
        if (wrTcon)
            tconNext = WriteData[2:0];
        if (overflow && !wrTl && tcon[TCON_IE])
            tconNext[TCON_ST] = 1'b1;
    end

    // Register update; reset wins over any store in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wrTh)
                th <= WriteData;
            tl   <= tlNext;
            tcon <= tconNext;
        end
    end

    // Load data mux; zero whenever the access is not a read of this block
    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            case (sel)
                SEL_TH:   ReadData = th;
                SEL_TL:   ReadData = tl;
                SEL_TCON: ReadData = {{(WIDTH-3){1'b0}}, tcon};
                default:  ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: stimulus pushes hand-computed expected
// bus/IRQ values into a scoreboard queue, and a monitor compares them
// against the DUT on the falling edge of the same cycle.
module tb_irq_timer;
    import irq_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    typedef struct {
        string       name;
        logic [31:0] readData;
        logic        hit;
        logic        irq;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        IRQ;

    expect_t scoreboard[$];
    int      vectorsApplied;
    int      miscompares;

    irq_timer #(
        .BASE_ADDR(BASE),
        .WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Hit(Hit),
        .IRQ(IRQ)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: pop one expectation per cycle and compare mid-cycle
    always @(negedge clk) begin
        if (scoreboard.size() > 0) begin
            expect_t e;
            e = scoreboard.pop_front();
            vectorsApplied++;
            if (ReadData !== e.readData || Hit !== e.hit || IRQ !== e.irq) begin
                miscompares++;
                $display("[TB] FAIL %s: got ReadData=%h Hit=%b IRQ=%b, want ReadData=%h Hit=%b IRQ=%b",
                         e.name, ReadData, Hit, IRQ, e.readData, e.hit, e.irq);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd);
        MemRead   = rd;
        MemWrite  = wr;
        Addr      = a;
        WriteData = wd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expRead,
                               input logic expHit, input logic expIrq);
        expect_t e;
        e.name     = name;
        e.readData = expRead;
        e.hit      = expHit;
        e.irq      = expIrq;
        scoreboard.push_back(e);
    endtask

    task automatic writeReg(input logic [31:0] ofs, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, BASE + ofs, data);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic readCheck(input string name, input logic [31:0] ofs,
                             input logic [31:0] expRead, input logic expIrq);
        applyStimulus(1'b1, 1'b0, BASE + ofs, 32'h0);
        checkOutput(name, expRead, 1'b1, expIrq);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic writeReadCheck(input string name, input logic [31:0] ofs,
                                  input logic [31:0] data, input logic [31:0] expRead,
                                  input logic expIrq);
        applyStimulus(1'b1, 1'b1, BASE + ofs, data);
        checkOutput(name, expRead, 1'b1, expIrq);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic missCheck(input string name, input logic [31:0] a, input logic expIrq);
        applyStimulus(1'b1, 1'b1, a, 32'hDEAD_BEEF);
        checkOutput(name, 32'h0, 1'b0, expIrq);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Directed sequence; each comment tracks TL/TCON as seen after the edge
    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        readCheck("rstTh",   TH_OFS,   32'h0, 1'b0);
        readCheck("rstTl",   TL_OFS,   32'h0, 1'b0);
        readCheck("rstTcon", TCON_OFS, 32'h0, 1'b0);

        // Periodic interrupt: reload value FFFF_FFFC gives a 4-cycle period
        writeReg(TH_OFS, 32'hFFFF_FFFC);
        writeReg(TL_OFS, 32'hFFFF_FFFC);
        writeReg(TCON_OFS, 32'h3);
        readCheck("perTl0", TL_OFS, 32'hFFFF_FFFC, 1'b0);
        readCheck("perTl1", TL_OFS, 32'hFFFF_FFFD, 1'b0);
        readCheck("perTl2", TL_OFS, 32'hFFFF_FFFE, 1'b0);
        readCheck("perTl3", TL_OFS, 32'hFFFF_FFFF, 1'b0);
        readCheck("perReload", TL_OFS, 32'hFFFF_FFFC, 1'b1);
        readCheck("perHold",   TL_OFS, 32'hFFFF_FFFD, 1'b1);
        // TL=FFFE now; clearing status lands on the edge TL becomes FFFF
        writeReg(TCON_OFS, 32'h3);
        readCheck("clrTcon", TCON_OFS, 32'h3, 1'b0);
        readCheck("reRise",  TCON_OFS, 32'h7, 1'b1);

        // Clear/overflow collision: the clear lands in the overflow cycle
        readCheck("colTlD", TL_OFS, 32'hFFFF_FFFD, 1'b1);
        readCheck("colTlE", TL_OFS, 32'hFFFF_FFFE, 1'b1);
        writeReadCheck("colPreWrite", TCON_OFS, 32'h3, 32'h7, 1'b1);
        readCheck("colTcon", TCON_OFS, 32'h7, 1'b1);
        readCheck("colTl",   TL_OFS,   32'hFFFF_FFFD, 1'b1);

        // Interrupt disabled: reload still happens, status stays clear
        writeReg(TCON_OFS, 32'h1);
        readCheck("disTlF",  TL_OFS,   32'hFFFF_FFFF, 1'b0);
        readCheck("disTcon", TCON_OFS, 32'h1, 1'b0);
        readCheck("disTlD",  TL_OFS,   32'hFFFF_FFFD, 1'b0);

        // TL store in the overflow cycle: stored value wins, no status
        writeReg(TCON_OFS, 32'h3);
        writeReg(TL_OFS, 32'hFFFF_FFFF);
        writeReadCheck("tlColPre", TL_OFS, 32'h5, 32'hFFFF_FFFF, 1'b0);
        readCheck("tlColTl",   TL_OFS,   32'h5, 1'b0);
        readCheck("tlColTcon", TCON_OFS, 32'h3, 1'b0);

        // Stop counting (TL 7 -> 8 on the stopping edge), then probe misses
        writeReg(TCON_OFS, 32'h0);
        missCheck("missPlus12", BASE + 32'd12, 1'b0);
        missCheck("missPlus2",  BASE + 32'd2,  1'b0);
        missCheck("missMinus4", BASE - 32'd4,  1'b0);
        readCheck("missTh",   TH_OFS,   32'hFFFF_FFFC, 1'b0);
        readCheck("missTl",   TL_OFS,   32'h8, 1'b0);
        readCheck("missTcon", TCON_OFS, 32'h0, 1'b0);

        // Software-set status, then mask via interrupt enable
        writeReg(TCON_OFS, 32'h6);
        readCheck("swSet",  TCON_OFS, 32'h6, 1'b1);
        writeReg(TCON_OFS, 32'hFFFF_FFFC);
        readCheck("swMask", TCON_OFS, 32'h4, 1'b0);

        // Reset mid-interrupt with a concurrent store; reset must win
        writeReg(TCON_OFS, 32'h7);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, BASE + TH_OFS, 32'h1234_5678);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        readCheck("rst2Th",   TH_OFS,   32'h0, 1'b0);
        readCheck("rst2Tl",   TL_OFS,   32'h0, 1'b0);
        readCheck("rst2Tcon", TCON_OFS, 32'h0, 1'b0);

        tick();
        tick();
        if (scoreboard.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d expectations left, want 0", scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped reload timer that generates the `IRQ` input consumed by the pipeline's instruction decoder. Sits on the MEM-stage data bus beside data memory, holds TH/TL/TCON, counts every cycle when enabled, and raises a level interrupt on TL overflow. The decoder's `PC_31` gating masks `IRQ` while the handler runs; the handler clears it by writing TCON.

## Interface
Parameters:
- `BASE_ADDR`, 32'h4000_0000: byte address of TH; TL at +4, TCON at +8.
- `WIDTH`, 32: TH/TL width; also bus data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `MemRead`  in  1  MEM-stage load strobe.
- `MemWrite`  in  1  MEM-stage store strobe.
- `Addr`  in  32  MEM-stage byte address.
- `WriteData`  in  WIDTH  store data.
- `ReadData`  out  WIDTH  load data; combinational.
- `Hit`  out  1  `Addr` decodes to TH, TL or TCON; combinational, data-mux select.
- `IRQ`  out  1  interrupt request to decoder; registered-state derived.

## Operation
- Decode: exact word match on `BASE_ADDR`, +4, +8; `Addr[1:0]` must be 0, otherwise no hit. Other addresses ignored.
- TCON bits: [0] count enable, [1] interrupt enable, [2] interrupt status. Bits [WIDTH-1:3] read 0, writes discarded.
- `IRQ = TCON[1] & TCON[2]`.
- Counting (TCON[0]=1): if TL == all-ones, TL <= TH, and TCON[2] <= 1 when TCON[1]=1; else TL <= TL+1 (wraps modulo 2^WIDTH). TCON[0]=0: TL holds.
- Writes (`MemWrite` & hit): TH/TL/TCON[2:0] take `WriteData`.
- Reads (`MemRead` & hit): `ReadData` = selected register's current value; else `ReadData` = 0.
- `MemRead` and `MemWrite` both high: write occurs; read returns pre-write value.
- Priority rules:
  - Write to TL in an overflow cycle: written value wins; no reload.
  - Write to TCON clearing bit 2 in an overflow cycle with TCON[1]=1 (pre-write value): status is set, not cleared. No interrupt is lost.
  - Write to TH in an overflow cycle: reload uses old TH; new TH takes effect at the next overflow.
  - Write to TCON setting TCON[0]: counting starts the following cycle.
- Software may set TCON[2] directly; `IRQ` follows.

## Timing
- Reset: TH=0, TL=0, TCON=0, `IRQ`=0. `ReadData`/`Hit` follow inputs combinationally.
- Reset mid-count, or mid-interrupt: all state cleared on that edge; reset overrides any concurrent write.
- Period with TCON[0]=1: 2^WIDTH − TH cycles between overflows.
- TL == all-ones is sampled at edge N. `IRQ` is high after edge N, and TL = TH after edge N.
- `IRQ` stays high until TCON[2] or TCON[1] is written to 0 (or reset); there is no auto-clear.
- Write latency: value is visible to reads the cycle after the store's edge.

## Structure
- Shared package: address offsets (`TH_OFS`=0, `TL_OFS`=4, `TCON_OFS`=8) and TCON bit indices (`TCON_EN`, `TCON_IE`, `TCON_ST`). The system-bus peripheral decoder reuses these.
- Single module; no sub-module warranted. Address decode, registers and the read mux are inline.

## Test plan
- Reset: assert `reset` for 2 cycles mid-count with TCON=3'b111 -> TH=TL=TCON=0, `IRQ`=0 on the next cycle; reads of all three addresses return 0.
- Periodic IRQ: TH=TL=32'hFFFF_FFFC, TCON=3'b011 -> TL sequence FFFC, FFFD, FFFE, FFFF, FFFC; `IRQ` rises the cycle TL returns to FFFC and stays high. Clear by writing TCON=3'b011 -> `IRQ` low next cycle; it rises again 4 cycles after the prior rise.
- Disabled interrupt: TCON=3'b001, overflow occurs -> TL reloads, TCON reads 3'b001, `IRQ` stays 0.
- Clear/overflow collision: a TCON=3'b011 write lands in the overflow cycle -> TCON reads 3'b111, `IRQ`=1.
- TL write collision: TL=FFFF_FFFF with counting on; write TL=5 in the same cycle -> TL=5 next cycle, no reload, TCON[2] unchanged.
- Decode: `Addr`=BASE+12, BASE+2, BASE−4 -> `Hit`=0, `ReadData`=0, no register changes. `Addr`=BASE+4 with `MemRead` -> `Hit`=1, `ReadData`=TL.
